// File: rtl/dataless_pkg.sv
// Shared definitions for the dataless handshake blocks (fork / join / merge).
// Holds the pending-bit reset value, the handshake vector type and a mask helper.
package dataless_pkg;

   // Value loaded into a fork pending bit on reset and on re-arm.
   localparam logic FORK_PENDING_RESET = 1'b1;

   // Widest handshake vector any dataless block in this family supports.
   localparam int unsigned DATALESS_MAX_SIZE = 32;

   // Handshake vector type. Blocks use the low SIZE bits.
   typedef logic [DATALESS_MAX_SIZE-1:0] hs_vec_t;

   // Returns a mask with the low 'size' bits set. Reduction logic uses it
   // to tie off the unused upper lanes of an hs_vec_t.
   function automatic hs_vec_t hs_mask(input int unsigned size);
      hs_vec_t m;
      m = '0;
      for (int unsigned i = 0; i < DATALESS_MAX_SIZE; i++) begin
         m[i] = (i < size);
      end
      return m;
   endfunction

endpackage : dataless_pkg

// File: rtl/eager_fork_register_block_dataless.sv
// One lane of the dataless eager fork. It holds the "still owed" bit for one
// output, gates the shared token onto that output, and reports whether this
// lane can let the token go this cycle.
module eager_fork_register_block_dataless
   import dataless_pkg::*;
(
   input  logic clk,
   input  logic rst,            // synchronous, active-low
   input  logic ins_valid,      // shared upstream token valid
   input  logic outs_ready_i,   // this lane's consumer ready
   input  logic all_ready,      // fork-wide ins_ready (every lane ok)
   output logic outs_valid_i,   // this lane's token valid
   output logic ok_i            // lane has taken, or is taking, the token
);

   logic pending_q;
   logic pending_d;

   // Next pending: re-arm when the whole fork releases the token, clear when
   // this lane takes it alone, and hold while no token is present.
   always_comb begin
      pending_d = pending_q;
      if (ins_valid) begin
         if (all_ready) begin
            pending_d = FORK_PENDING_RESET;
         end else begin
            pending_d = pending_q & ~outs_ready_i;
         end
      end
   end

   // Pending register; an active-low reset re-arms the lane.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_q <= FORK_PENDING_RESET;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Lane outputs. Both are combinational so a ready consumer takes the
   // token with zero latency. ok_i ignores ins_valid on purpose, so
   // ins_ready never depends on ins_valid.
   always_comb begin
      outs_valid_i = ins_valid & pending_q;
      ok_i         = ~pending_q | outs_ready_i;
   end

endmodule : eager_fork_register_block_dataless

// File: rtl/eager_fork_dataless.sv
// Dataless eager fork. It copies one valid/ready token stream to SIZE
// consumers. Each consumer may take the token in a different cycle. The
// upstream token is released only once every consumer has taken it.
// Optional macro EAGER_FORK_PROTOCOL_CHECK_EN adds simulation-only protocol
// checks. The synthesised logic and port list are the same either way.
module eager_fork_dataless
   import dataless_pkg::*;
#(
   parameter int unsigned SIZE = 2
)
(
   input  logic            clk,
   input  logic            rst,         // synchronous, active-low
   input  logic            ins_valid,
   output logic            ins_ready,
   output logic [SIZE-1:0] outs_valid,
   input  logic [SIZE-1:0] outs_ready
);

   logic [SIZE-1:0] ok;
   hs_vec_t         ok_ext;

   genvar gi;

   // One pending-bit lane per output.
   generate
      for (gi = 0; gi < SIZE; gi++) begin : gen_lane
         eager_fork_register_block_dataless u_lane (
            .clk          (clk),
            .rst          (rst),
            .ins_valid    (ins_valid),
            .outs_ready_i (outs_ready[gi]),
            .all_ready    (ins_ready),
            .outs_valid_i (outs_valid[gi]),
            .ok_i         (ok[gi])
         );
      end
   endgenerate

   // The token can be released once every lane is ok. Unused upper lanes are
   // forced to 1 so they do not block the AND.
   always_comb begin
      ok_ext            = ~hs_mask(SIZE);
      ok_ext[SIZE-1:0]  = ok;
      ins_ready         = &ok_ext;
   end

`ifdef EAGER_FORK_PROTOCOL_CHECK_EN
   logic [SIZE-1:0] chk_pending;
   logic            chk_armed_q;
   logic            chk_stall_q;
   logic            chk_valid_q;
   logic [SIZE-1:0] chk_ov_q;
   logic [SIZE-1:0] chk_xfer_q;

   // Collect the lane pending bits for the checks below.
   generate
      for (gi = 0; gi < SIZE; gi++) begin : gen_chk_tap
         assign chk_pending[gi] = gen_lane[gi].u_lane.pending_q;
      end
   endgenerate

   // Check the upstream hold rule, that pending is never empty, and that no
   // output valid drops without a transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (chk_armed_q && chk_stall_q && !ins_valid) begin
            $error("%m: ins_valid dropped while the token was stalled");
         end
         if (chk_pending == '0) begin
            $error("%m: pending reached all zeros");
         end
         for (int i = 0; i < int'(SIZE); i++) begin
            if (chk_armed_q && chk_valid_q && ins_valid &&
                chk_ov_q[i] && !chk_xfer_q[i] && !outs_valid[i]) begin
               $error("%m: outs_valid[%0d] fell without a transfer", i);
            end
         end
      end
      chk_armed_q <= rst;
      chk_stall_q <= ins_valid & ~ins_ready;
      chk_valid_q <= ins_valid;
      chk_ov_q    <= outs_valid;
      chk_xfer_q  <= outs_valid & outs_ready;
   end
`endif

endmodule : eager_fork_dataless

// File: tb/tb_eager_fork_dataless.sv
// Self-checking bench for eager_fork_dataless (SIZE=2). Each stimulus row
// pushes its expected {outs_valid, ins_ready} to a scoreboard queue. The
// value is popped and compared on the following falling edge.
module tb_eager_fork_dataless;

   localparam int unsigned SIZE = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            ins_valid;
   logic            ins_ready;
   logic [SIZE-1:0] outs_valid;
   logic [SIZE-1:0] outs_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected {outs_valid[1:0], ins_ready}
   logic [2:0] sb_q[$];

   always #5 clk = ~clk;

   eager_fork_dataless #(.SIZE(SIZE)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready)
   );

   // Row layout: {rst, ins_valid, outs_ready[1:0], exp_outs_valid[1:0], exp_ins_ready}
   task automatic drive(input logic [6:0] row);
      @(posedge clk);
      #1;
      rst        = row[6];
      ins_valid  = row[5];
      outs_ready = row[4:3];
      sb_q.push_back(row[2:0]);
   endtask

   task automatic test_reset();
      logic [6:0] tbl [3];
      logic [2:0] exp_v;
      tbl = '{7'b0_1_00_11_0, 7'b1_1_00_11_0, 7'b1_1_00_11_0};
      for (int i = 0; i < 3; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({outs_valid, ins_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL reset[%0d]: outs_valid=%b ins_ready=%b, want outs_valid=%b ins_ready=%b",
                     i, outs_valid, ins_ready, exp_v[2:1], exp_v[0]);
         end else begin
            $display("reset[%0d]: outs_valid=%b ins_ready=%b ok", i, outs_valid, ins_ready);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [6:0] tbl [4];
      logic [2:0] exp_v;
      tbl = '{7'b1_1_11_11_1, 7'b1_1_00_11_0, 7'b1_1_11_11_1, 7'b1_0_00_00_0};
      for (int i = 0; i < 4; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({outs_valid, ins_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL simultaneous[%0d]: outs_valid=%b ins_ready=%b, want outs_valid=%b ins_ready=%b",
                     i, outs_valid, ins_ready, exp_v[2:1], exp_v[0]);
         end else begin
            $display("simultaneous[%0d]: outs_valid=%b ins_ready=%b ok", i, outs_valid, ins_ready);
         end
      end
   endtask

   task automatic test_staggered();
      logic [6:0] tbl [8];
      logic [2:0] exp_v;
      // Output 0 first, then output 1; after that the opposite order, with a
      // redundant ready on output 1 while output 0 is still owed.
      tbl = '{7'b1_1_01_11_0, 7'b1_1_10_10_1, 7'b1_0_00_00_0,
              7'b1_1_00_11_0, 7'b1_1_10_11_0, 7'b1_1_10_01_0,
              7'b1_1_01_01_1, 7'b1_0_00_00_0};
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({outs_valid, ins_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL staggered[%0d]: outs_valid=%b ins_ready=%b, want outs_valid=%b ins_ready=%b",
                     i, outs_valid, ins_ready, exp_v[2:1], exp_v[0]);
         end else begin
            $display("staggered[%0d]: outs_valid=%b ins_ready=%b ok", i, outs_valid, ins_ready);
         end
      end
   endtask

   task automatic test_idle_ready();
      logic [6:0] tbl [9];
      logic [2:0] exp_v;
      // While ins_valid is low, ready outputs must not clear pending.
      tbl = '{7'b1_0_11_00_1, 7'b1_0_11_00_1, 7'b1_0_11_00_1,
              7'b1_1_11_11_1, 7'b1_0_00_00_0, 7'b1_0_01_00_0,
              7'b1_1_00_11_0, 7'b1_1_11_11_1, 7'b1_0_00_00_0};
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({outs_valid, ins_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL idle_ready[%0d]: outs_valid=%b ins_ready=%b, want outs_valid=%b ins_ready=%b",
                     i, outs_valid, ins_ready, exp_v[2:1], exp_v[0]);
         end else begin
            $display("idle_ready[%0d]: outs_valid=%b ins_ready=%b ok", i, outs_valid, ins_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] tbl [7];
      logic [2:0] exp_v;
      int xfer0, xfer1, xfer_in;
      xfer0   = 0;
      xfer1   = 0;
      xfer_in = 0;
      tbl = '{7'b1_1_01_11_0, 7'b1_1_10_10_1, 7'b1_1_11_11_1,
              7'b1_1_11_11_1, 7'b1_1_10_11_0, 7'b1_1_01_01_1,
              7'b1_0_00_00_0};
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         if (outs_valid[0] && outs_ready[0]) xfer0++;
         if (outs_valid[1] && outs_ready[1]) xfer1++;
         if (ins_valid && ins_ready)         xfer_in++;
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({outs_valid, ins_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: outs_valid=%b ins_ready=%b, want outs_valid=%b ins_ready=%b",
                     i, outs_valid, ins_ready, exp_v[2:1], exp_v[0]);
         end else begin
            $display("back_to_back[%0d]: outs_valid=%b ins_ready=%b ok", i, outs_valid, ins_ready);
         end
      end
      n_cmp++;
      if (xfer0 !== 4 || xfer1 !== 4 || xfer_in !== 4) begin
         n_fail++;
         $display("FAIL back_to_back_counts: out0=%0d out1=%0d in=%0d, want 4/4/4", xfer0, xfer1, xfer_in);
      end else begin
         $display("back_to_back_counts: out0=%0d out1=%0d in=%0d ok", xfer0, xfer1, xfer_in);
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] tbl [5];
      logic [2:0] exp_v;
      // Output 0 takes the token, then a reset re-offers it to output 0.
      tbl = '{7'b1_1_01_11_0, 7'b0_1_00_10_0, 7'b1_1_00_11_0,
              7'b1_1_11_11_1, 7'b1_0_00_00_0};
      for (int i = 0; i < 5; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({outs_valid, ins_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid[%0d]: outs_valid=%b ins_ready=%b, want outs_valid=%b ins_ready=%b",
                     i, outs_valid, ins_ready, exp_v[2:1], exp_v[0]);
         end else begin
            $display("reset_mid[%0d]: outs_valid=%b ins_ready=%b ok", i, outs_valid, ins_ready);
         end
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      ins_valid  = 1'b1;
      outs_ready = '0;
      test_reset();
      test_simultaneous();
      test_staggered();
      test_idle_ready();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_eager_fork_dataless
